// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE/MEM/data-RAM/forwarding signal bundle for the execute stage
// Master is the surrounding pipeline; slave is the execute stage itself.
interface exe_stage_if;
   logic         EXE_signal_valid;
   logic [150:0] EXE_signal;
   logic         MEM_allowin;
   logic         EXE_allowin;
   logic         MEM_signal_valid;
   logic [70:0]  MEM_signal;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic [37:0]  EXE_fwd;
   logic         EXE_is_load;

   modport master (
      output EXE_signal_valid,
      output EXE_signal,
      output MEM_allowin,
      input  EXE_allowin,
      input  MEM_signal_valid,
      input  MEM_signal,
      input  data_sram_en,
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      input  EXE_fwd,
      input  EXE_is_load
   );

   modport slave (
      input  EXE_signal_valid,
      input  EXE_signal,
      input  MEM_allowin,
      output EXE_allowin,
      output MEM_signal_valid,
      output MEM_signal,
      output data_sram_en,
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      output EXE_fwd,
      output EXE_is_load
   );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - single-cycle execute stage: payload register, one-hot ALU, data RAM request, forwarding
// Holds one instruction from ID and presents its result to MEM and the data RAM in the following cycle.
module exe_stage (
   input  logic        clk,
   input  logic        reset,
   exe_stage_if.slave  bus
);

   logic         exe_valid_q;
   logic         exe_valid_d;
   logic [150:0] payload_q;
   logic [150:0] payload_d;

   logic         exe_readygo;
   logic         exe_allowin;

   logic [31:0]  pc;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rkd_value;
   logic         res_from_mem;
   logic [3:0]   mem_we;
   logic [11:0]  alu_op;
   logic [31:0]  alu_src1;
   logic [31:0]  alu_src2;

   logic [31:0]  add_res;
   logic [31:0]  sub_res;
   logic [31:0]  slt_res;
   logic [31:0]  sltu_res;
   logic [31:0]  and_res;
   logic [31:0]  nor_res;
   logic [31:0]  or_res;
   logic [31:0]  xor_res;
   logic [31:0]  sll_res;
   logic [31:0]  srl_res;
   logic [31:0]  sra_res;
   logic [31:0]  lui_res;
   logic [4:0]   shamt;
   logic [31:0]  alu_result;
   logic         mem_go;

   assign pc           = payload_q[150:119];
   assign rf_we        = payload_q[118];
   assign rf_waddr     = payload_q[117:113];
   assign rkd_value    = payload_q[112:81];
   assign res_from_mem = payload_q[80];
   assign mem_we       = payload_q[79:76];
   assign alu_op       = payload_q[75:64];
   assign alu_src1     = payload_q[63:32];
   assign alu_src2     = payload_q[31:0];

   assign exe_readygo = 1'b1;
   assign exe_allowin = !exe_valid_q || (exe_readygo && bus.MEM_allowin);

   // Bubbles update the valid bit but leave the payload untouched.
   always_comb begin
      exe_valid_d = exe_valid_q;
      payload_d   = payload_q;
      if (exe_allowin) begin
         exe_valid_d = bus.EXE_signal_valid;
         if (bus.EXE_signal_valid) begin
            payload_d = bus.EXE_signal;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exe_valid_q <= 1'b0;
         payload_q   <= '0;
      end else begin
         exe_valid_q <= exe_valid_d;
         payload_q   <= payload_d;
      end
   end

   assign shamt    = alu_src2[4:0];
   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
   assign sltu_res = {31'd0, (alu_src1 < alu_src2)};
   assign and_res  = alu_src1 & alu_src2;
   assign nor_res  = ~(alu_src1 | alu_src2);
   assign or_res   = alu_src1 | alu_src2;
   assign xor_res  = alu_src1 ^ alu_src2;
   assign sll_res  = alu_src1 << shamt;
   assign srl_res  = alu_src1 >> shamt;
   assign sra_res  = $unsigned($signed(alu_src1) >>> shamt);
   assign lui_res  = alu_src2;

   // Gated OR-merge: an all-zero alu_op naturally yields zero.
   assign alu_result = ({32{alu_op[0]}}  & add_res)
                     | ({32{alu_op[1]}}  & sub_res)
                     | ({32{alu_op[2]}}  & slt_res)
                     | ({32{alu_op[3]}}  & sltu_res)
                     | ({32{alu_op[4]}}  & and_res)
                     | ({32{alu_op[5]}}  & nor_res)
                     | ({32{alu_op[6]}}  & or_res)
                     | ({32{alu_op[7]}}  & xor_res)
                     | ({32{alu_op[8]}}  & sll_res)
                     | ({32{alu_op[9]}}  & srl_res)
                     | ({32{alu_op[10]}} & sra_res)
                     | ({32{alu_op[11]}} & lui_res);

   // RAM access fires only in the cycle MEM takes the instruction, so a stalled store writes once.
   assign mem_go = exe_valid_q && bus.MEM_allowin;

   assign bus.EXE_allowin      = exe_allowin;
   assign bus.MEM_signal_valid = exe_valid_q && exe_readygo;
   assign bus.MEM_signal       = {pc, rf_we, rf_waddr, res_from_mem, alu_result};
   assign bus.data_sram_en     = mem_go && (res_from_mem || (|mem_we));
   assign bus.data_sram_we     = mem_we & {4{mem_go}};
   assign bus.data_sram_addr   = alu_result;
   assign bus.data_sram_wdata  = rkd_value;
   assign bus.EXE_fwd          = {exe_valid_q && rf_we && (rf_waddr != 5'd0), rf_waddr, alu_result};
   assign bus.EXE_is_load      = exe_valid_q && res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   exe_stage_if bus ();

   exe_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [150:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                       input logic [31:0] rkd, input logic rfm, input logic [3:0] mwe,
                                       input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2);
      return {pc, we, wa, rkd, rfm, mwe, op, s1, s2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.MEM_allowin = 1'b0;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h900, 1'b1, 5'd4, 32'h1, 1'b1, 4'hF, 12'h001, 32'h1, 32'h2);
      tick();
      tick();
      tests_run++;
      if (bus.EXE_allowin !== 1'b1) begin tests_failed++; $display("FAIL reset_allowin got %b want 1", bus.EXE_allowin); end
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_msv got %b want 0", bus.MEM_signal_valid); end
      tests_run++;
      if (bus.data_sram_en !== 1'b0 || bus.data_sram_we !== 4'h0) begin tests_failed++; $display("FAIL reset_sram got en=%b we=%h want 0/0", bus.data_sram_en, bus.data_sram_we); end
      tests_run++;
      if (bus.EXE_fwd[37] !== 1'b0 || bus.EXE_is_load !== 1'b0) begin tests_failed++; $display("FAIL reset_fwd got fwd_valid=%b is_load=%b want 0/0", bus.EXE_fwd[37], bus.EXE_is_load); end
      tests_run++;
      if (bus.MEM_signal !== 71'd0) begin tests_failed++; $display("FAIL reset_payload got %h want 0", bus.MEM_signal); end
      @(negedge clk);
      reset = 1'b0;
      bus.EXE_signal_valid = 1'b0;
      bus.MEM_allowin = 1'b1;
   endtask

   task automatic test_first_accept();
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h1000, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, 12'h001, 32'h3, 32'h4);
      tick();
      bus.EXE_signal_valid = 1'b0;
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b1 || bus.MEM_signal[70:39] !== 32'h1000) begin tests_failed++; $display("FAIL first_accept got msv=%b pc=%h want 1/1000", bus.MEM_signal_valid, bus.MEM_signal[70:39]); end
      tick();
   endtask

   task automatic test_alu();
      logic [11:0] ops [13];
      logic [31:0] s1s [13];
      logic [31:0] s2s [13];
      logic [31:0] exps[13];
      ops[0]  = 12'h001; s1s[0]  = 32'h7FFFFFFF; s2s[0]  = 32'h1;        exps[0]  = 32'h80000000;
      ops[1]  = 12'h002; s1s[1]  = 32'h5;        s2s[1]  = 32'h7;        exps[1]  = 32'hFFFFFFFE;
      ops[2]  = 12'h004; s1s[2]  = 32'hFFFFFFFF; s2s[2]  = 32'h1;        exps[2]  = 32'h1;
      ops[3]  = 12'h008; s1s[3]  = 32'hFFFFFFFF; s2s[3]  = 32'h1;        exps[3]  = 32'h0;
      ops[4]  = 12'h010; s1s[4]  = 32'hF0F0F0F0; s2s[4]  = 32'hFF00FF00; exps[4]  = 32'hF000F000;
      ops[5]  = 12'h020; s1s[5]  = 32'h0F0F0000; s2s[5]  = 32'h0000F0F0; exps[5]  = 32'hF0F00F0F;
      ops[6]  = 12'h040; s1s[6]  = 32'h12340000; s2s[6]  = 32'h00005678; exps[6]  = 32'h12345678;
      ops[7]  = 12'h080; s1s[7]  = 32'hFFFF0000; s2s[7]  = 32'h0F0F0F0F; exps[7]  = 32'hF0F00F0F;
      ops[8]  = 12'h100; s1s[8]  = 32'h1;        s2s[8]  = 32'h21;       exps[8]  = 32'h2;
      ops[9]  = 12'h200; s1s[9]  = 32'h80000000; s2s[9]  = 32'h4;        exps[9]  = 32'h08000000;
      ops[10] = 12'h400; s1s[10] = 32'h80000000; s2s[10] = 32'h4;        exps[10] = 32'hF8000000;
      ops[11] = 12'h800; s1s[11] = 32'h0000AAAA; s2s[11] = 32'h12345000; exps[11] = 32'h12345000;
      ops[12] = 12'h000; s1s[12] = 32'h5;        s2s[12] = 32'h6;        exps[12] = 32'h0;
      bus.MEM_allowin = 1'b1;
      for (int i = 0; i < 13; i++) begin
         bus.EXE_signal_valid = 1'b1;
         bus.EXE_signal = mk(32'h2000 + 32'(i * 4), 1'b1, 5'd2, 32'h0, 1'b0, 4'h0, ops[i], s1s[i], s2s[i]);
         tick();
         tests_run++;
         if (bus.MEM_signal[31:0] !== exps[i] || bus.EXE_fwd[31:0] !== exps[i]) begin
            tests_failed++;
            $display("FAIL alu_op_%03h got %h (fwd %h) want %h", ops[i], bus.MEM_signal[31:0], bus.EXE_fwd[31:0], exps[i]);
         end
         tests_run++;
         if (bus.MEM_signal_valid !== 1'b1 || bus.data_sram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_ctrl_%0d got msv=%b en=%b want 1/0", i, bus.MEM_signal_valid, bus.data_sram_en);
         end
      end
      bus.EXE_signal_valid = 1'b0;
      tick();
   endtask

   task automatic test_store_stall();
      bus.MEM_allowin = 1'b0;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h3000, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 4'hF, 12'h001, 32'h100, 32'h8);
      tick();
      bus.EXE_signal_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (bus.data_sram_we !== 4'h0 || bus.EXE_allowin !== 1'b0 || bus.MEM_signal_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_stall_c%0d got we=%h allowin=%b msv=%b want 0/0/1", i, bus.data_sram_we, bus.EXE_allowin, bus.MEM_signal_valid);
         end
         if (i < 2) tick();
      end
      bus.MEM_allowin = 1'b1;
      #1;
      tests_run++;
      if (bus.data_sram_we !== 4'hF || bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== 32'h108 || bus.data_sram_wdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL store_release got en=%b we=%h addr=%h wdata=%h want 1/F/108/DEADBEEF", bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata);
      end
      tests_run++;
      if (bus.EXE_allowin !== 1'b1) begin tests_failed++; $display("FAIL store_release_allowin got %b want 1", bus.EXE_allowin); end
      tick();
      tests_run++;
      if (bus.data_sram_we !== 4'h0 || bus.MEM_signal_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_once got we=%h msv=%b want 0/0", bus.data_sram_we, bus.MEM_signal_valid);
      end
   endtask

   task automatic test_load_fwd();
      bus.MEM_allowin = 1'b1;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h4000, 1'b1, 5'd5, 32'h0, 1'b1, 4'h0, 12'h001, 32'h200, 32'h4);
      tick();
      bus.EXE_signal_valid = 1'b0;
      tests_run++;
      if (bus.EXE_is_load !== 1'b1 || bus.EXE_fwd !== {1'b1, 5'd5, 32'h204}) begin
         tests_failed++;
         $display("FAIL load_fwd got is_load=%b fwd=%h want 1/%h", bus.EXE_is_load, bus.EXE_fwd, {1'b1, 5'd5, 32'h204});
      end
      tests_run++;
      if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== 4'h0 || bus.data_sram_addr !== 32'h204) begin
         tests_failed++;
         $display("FAIL load_sram got en=%b we=%h addr=%h want 1/0/204", bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr);
      end
      tick();
      tests_run++;
      if (bus.EXE_is_load !== 1'b0 || bus.EXE_fwd[37] !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_gone got is_load=%b fwd_valid=%b want 0/0", bus.EXE_is_load, bus.EXE_fwd[37]);
      end
   endtask

   task automatic test_r0_fwd();
      bus.MEM_allowin = 1'b1;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h5000, 1'b1, 5'd0, 32'h0, 1'b0, 4'h0, 12'h001, 32'h1, 32'h2);
      tick();
      tests_run++;
      if (bus.EXE_fwd !== {1'b0, 5'd0, 32'h3} || bus.MEM_signal_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL r0_fwd got fwd=%h msv=%b want %h/1", bus.EXE_fwd, bus.MEM_signal_valid, {1'b0, 5'd0, 32'h3});
      end
      bus.EXE_signal = mk(32'h5004, 1'b0, 5'd7, 32'h0, 1'b0, 4'h0, 12'h001, 32'h1, 32'h2);
      tick();
      tests_run++;
      if (bus.EXE_fwd[37] !== 1'b0 || bus.EXE_fwd[36:32] !== 5'd7) begin
         tests_failed++;
         $display("FAIL nowe_fwd got fwd_valid=%b dest=%0d want 0/7", bus.EXE_fwd[37], bus.EXE_fwd[36:32]);
      end
      bus.EXE_signal_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.MEM_allowin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.EXE_signal_valid = 1'b1;
         bus.EXE_signal = mk(32'h6000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'h0, 1'b0, 4'h0, 12'h001, 32'(i * 10), 32'h1);
         tick();
         tests_run++;
         if (bus.MEM_signal_valid !== 1'b1 || bus.MEM_signal[70:39] !== 32'h6000 + 32'(i * 4) ||
             bus.MEM_signal[31:0] !== 32'(i * 10 + 1) || bus.EXE_allowin !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_%0d got msv=%b pc=%h res=%h allowin=%b want 1/%h/%h/1", i, bus.MEM_signal_valid,
                     bus.MEM_signal[70:39], bus.MEM_signal[31:0], bus.EXE_allowin, 32'h6000 + 32'(i * 4), 32'(i * 10 + 1));
         end
      end
      bus.EXE_signal_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got msv=%b want 0", bus.MEM_signal_valid); end
   endtask

   task automatic test_bubble();
      bus.MEM_allowin = 1'b1;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h7000, 1'b1, 5'd9, 32'h0, 1'b0, 4'h0, 12'h040, 32'h11, 32'h22);
      tick();
      bus.EXE_signal_valid = 1'b0;
      bus.EXE_signal = mk(32'h6666, 1'b0, 5'd1, 32'hFFFFFFFF, 1'b1, 4'h3, 12'h002, 32'h9, 32'h9);
      tick();
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b0 || bus.MEM_signal !== {32'h7000, 1'b1, 5'd9, 1'b0, 32'h33}) begin
         tests_failed++;
         $display("FAIL bubble got msv=%b sig=%h want 0/%h", bus.MEM_signal_valid, bus.MEM_signal, {32'h7000, 1'b1, 5'd9, 1'b0, 32'h33});
      end
      tests_run++;
      if (bus.data_sram_en !== 1'b0 || bus.EXE_allowin !== 1'b1) begin
         tests_failed++;
         $display("FAIL bubble_ctrl got en=%b allowin=%b want 0/1", bus.data_sram_en, bus.EXE_allowin);
      end
   endtask

   task automatic test_reset_stall();
      bus.MEM_allowin = 1'b0;
      bus.EXE_signal_valid = 1'b1;
      bus.EXE_signal = mk(32'h8000, 1'b0, 5'd0, 32'hCAFEF00D, 1'b0, 4'hF, 12'h001, 32'h40, 32'h0);
      tick();
      bus.EXE_signal_valid = 1'b0;
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b1 || bus.data_sram_we !== 4'h0) begin
         tests_failed++;
         $display("FAIL rst_stall_hold got msv=%b we=%h want 1/0", bus.MEM_signal_valid, bus.data_sram_we);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (bus.MEM_signal_valid !== 1'b0 || bus.EXE_allowin !== 1'b1 || bus.data_sram_we !== 4'h0) begin
         tests_failed++;
         $display("FAIL rst_stall_async got msv=%b allowin=%b we=%h want 0/1/0", bus.MEM_signal_valid, bus.EXE_allowin, bus.data_sram_we);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.MEM_allowin = 1'b1;
      #1;
      tests_run++;
      if (bus.data_sram_we !== 4'h0 || bus.data_sram_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_stall_release got en=%b we=%h want 0/0", bus.data_sram_en, bus.data_sram_we);
      end
      tick();
      tests_run++;
      if (bus.data_sram_we !== 4'h0 || bus.MEM_signal_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_stall_after got we=%h msv=%b want 0/0", bus.data_sram_we, bus.MEM_signal_valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus.EXE_signal_valid = 1'b0;
      bus.EXE_signal = '0;
      bus.MEM_allowin = 1'b1;
      test_reset();
      test_first_accept();
      test_alu();
      test_store_stall();
      test_load_fwd();
      test_r0_fwd();
      test_back_to_back();
      test_bubble();
      test_reset_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 EXE_signal_valid  input  1  ID presents a valid instruction.
REQ-005 EXE_signal  input  151  ID payload, fields listed in REQ-006.
REQ-006 EXE_signal bit fields SHALL be:
- pc[150:119]
- rf_we[118]
- rf_waddr[117:113]
- rkd_value[112:81]
- res_from_mem[80]
- mem_we[79:76]
- alu_op[75:64]
- alu_src1[63:32]
- alu_src2[31:0]
REQ-007 MEM_allowin  input  1  MEM stage can accept this cycle.
REQ-008 EXE_allowin  output  1  EXE accepts from ID this cycle.
REQ-009 MEM_signal_valid  output  1  valid instruction offered to MEM.
REQ-010 MEM_signal  output  71  fields: pc[70:39], rf_we[38], rf_waddr[37:33], res_from_mem[32], alu_result[31:0].
REQ-011 data_sram_en  output  1  data RAM enable.
REQ-012 data_sram_we  output  4  data RAM byte write enables.
REQ-013 data_sram_addr  output  32  data RAM address.
REQ-014 data_sram_wdata  output  32  data RAM write data.
REQ-015 EXE_fwd  output  38  hazard/forward info: {fwd_valid[37], dest[36:32], alu_result[31:0]}.
REQ-016 EXE_is_load  output  1  valid load resident in EXE (drives Load_DataHazard upstream).

Function
REQ-017 EXE_readygo SHALL be constant 1 (single-cycle ALU).
REQ-018 EXE_allowin SHALL equal !EXE_valid | (EXE_readygo & MEM_allowin).
REQ-019 When EXE_allowin=1 at a clock edge, EXE_valid SHALL load EXE_signal_valid.
REQ-020 When EXE_allowin=0, EXE_valid and the payload register SHALL hold.
REQ-021 The payload register SHALL load EXE_signal only when EXE_allowin & EXE_signal_valid; a bubble SHALL not overwrite it.
REQ-022 Latency SHALL be: instruction accepted at edge N appears on MEM_signal/data_sram_* during cycle N+1.
REQ-023 MEM_signal_valid SHALL equal EXE_valid & EXE_readygo.
REQ-024 ALU SHALL be 32-bit, operate on registered src1/src2, and take alu_op one-hot:
- bit0: add
- bit1: sub
- bit2: slt (signed)
- bit3: sltu
- bit4: and
- bit5: nor
- bit6: or
- bit7: xor
- bit8: sll
- bit9: srl
- bit10: sra
- bit11: lu12i (result = src2)
REQ-025 Shift amount SHALL be src2[4:0]; add/sub SHALL wrap modulo 2^32; slt/sltu SHALL yield 0 or 1.
REQ-026 alu_result SHALL be the OR of per-op results gated by their alu_op bit; all-zero alu_op SHALL yield 0.
REQ-027 data_sram_en SHALL equal EXE_valid & MEM_allowin & (res_from_mem | (|mem_we)).
REQ-028 data_sram_we SHALL equal mem_we & {4{EXE_valid & MEM_allowin}}.
REQ-029 data_sram_addr SHALL be alu_result; data_sram_wdata SHALL be registered rkd_value.
REQ-030 A store stalled by MEM_allowin=0 SHALL be written exactly once, in the cycle MEM_allowin rises.
REQ-031 fwd_valid SHALL equal EXE_valid & rf_we & (rf_waddr != 0).
REQ-032 EXE_fwd.dest SHALL be rf_waddr and EXE_fwd.alu_result the current alu_result.
REQ-033 EXE_is_load SHALL equal EXE_valid & res_from_mem.
REQ-034 Simultaneous drain to MEM and accept from ID in one cycle SHALL sustain full throughput with no bubble.

Reset
REQ-035 While reset=1, EXE_valid and the payload register SHALL be 0 asynchronously.
REQ-036 Resulting outputs during reset SHALL be:
- EXE_allowin=1
- MEM_signal_valid=0
- data_sram_en=0, data_sram_we=0
- fwd_valid=0, EXE_is_load=0
REQ-037 Reset asserted mid-stall SHALL discard the held instruction; no memory write SHALL occur.
REQ-038 The first acceptance SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-039 add: src1=0x7FFFFFFF, src2=1, alu_op=0x001, MEM_allowin=1 -> next cycle alu_result=0x80000000, MEM_signal_valid=1, data_sram_en=0.
REQ-040 slt vs sltu: src1=0xFFFFFFFF, src2=1 -> slt result=1, sltu result=0; sra src1=0x80000000, src2=4 -> 0xF8000000.
REQ-041 Store stall: st with src1=0x100, src2=0x8, rkd=0xDEADBEEF, MEM_allowin=0 for 3 cycles -> data_sram_we=0 and EXE_allowin=0 throughout; on release, one cycle with we=0xF, addr=0x108, wdata=0xDEADBEEF.
REQ-042 Load into r5: EXE_is_load=1 and EXE_fwd={1,5,addr} for the resident cycle.
REQ-043 Writes to r0 SHALL give fwd_valid=0.
REQ-044 Back-to-back: 4 valid instructions, MEM_allowin=1 -> 4 consecutive MEM_signal_valid cycles in order.
REQ-045 Bubble: input valid=0 -> MEM_signal_valid=0 next cycle and the payload register unchanged.
REQ-046 Reset mid-stall: pending store held, reset pulsed -> data_sram_we never nonzero, MEM_signal_valid=0, EXE_allowin=1.
